// File: rtl/traffic_conflict_monitor_pkg.sv
// ============================================================================
// Module  : traffic_conflict_monitor_pkg
// Brief   : Aspect encodings, fault codes and sizing helpers for the monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package traffic_conflict_monitor_pkg;

    typedef enum logic [1:0] {
        ASP_RED    = 2'd0,
        ASP_YELLOW = 2'd1,
        ASP_GREEN  = 2'd2,
        ASP_BAD    = 2'd3
    } aspect_e;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_CONFLICT     = 3'd1,
        FC_STEP         = 3'd2,
        FC_SHORT_YELLOW = 3'd3,
        FC_SHORT_ALLRED = 3'd4,
        FC_ENCODING     = 3'd5
    } fault_code_e;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_conflict_monitor_aspect_tracker.sv
// ============================================================================
// Module  : traffic_conflict_monitor_aspect_tracker
// Brief   : Per-road previous-aspect register, yellow run counter and step checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_conflict_monitor_aspect_tracker
    import traffic_conflict_monitor_pkg::*;
#(
    parameter int MIN_YELLOW = 3
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] aspect,
    output logic       step_illegal,
    output logic       short_yellow,
    output logic       enter_green,
    output logic       enc_bad
);

    localparam int YW = cnt_width(MIN_YELLOW);
    localparam logic [YW-1:0] C_YEL_SAT = YW'(MIN_YELLOW);

    logic [1:0]    prev_q, prev_d;
    logic [YW-1:0] ycnt_q, ycnt_d;

    always_comb begin
        step_illegal = ((prev_q == ASP_GREEN)  && (aspect == ASP_RED))    ||
                       ((prev_q == ASP_RED)    && (aspect == ASP_YELLOW)) ||
                       ((prev_q == ASP_YELLOW) && (aspect == ASP_GREEN));
        short_yellow = (prev_q == ASP_YELLOW) && (aspect == ASP_RED) && (ycnt_q < C_YEL_SAT);
        enter_green  = (prev_q == ASP_RED) && (aspect == ASP_GREEN);
        enc_bad      = (aspect == ASP_BAD);

        prev_d = aspect;
        ycnt_d = '0;
        if (aspect == ASP_YELLOW) begin
            ycnt_d = (ycnt_q < C_YEL_SAT) ? ycnt_q + 1'b1 : ycnt_q;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            prev_q <= ASP_RED;
            ycnt_q <= '0;
        end else begin
            prev_q <= prev_d;
            ycnt_q <= ycnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
// ============================================================================
// Module  : traffic_conflict_monitor
// Brief   : Safety monitor on controller aspects; latches faults and flashes heads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_conflict_monitor
    import traffic_conflict_monitor_pkg::*;
#(
    parameter int MIN_YELLOW   = 3,
    parameter int MIN_ALLRED_C = 2,
    parameter int MIN_ALLRED_H = 0,
    parameter int FLASH_HALF   = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       fault_ack,
    output logic [1:0] hwy_lamp,
    output logic [1:0] cntry_lamp,
    output logic       lamp_en,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int AR_MAX = imax(MIN_ALLRED_C, MIN_ALLRED_H);
    localparam int AW     = cnt_width(AR_MAX);
    localparam int FW     = cnt_width(FLASH_HALF - 1);
    localparam logic [AW-1:0] C_AR_SAT   = AW'(AR_MAX);
    localparam logic [FW-1:0] C_FLASH_TC = FW'(FLASH_HALF - 1);

    logic w_h_step, w_h_short_y, w_h_enter_g, w_h_enc;
    logic w_c_step, w_c_short_y, w_c_enter_g, w_c_enc;
    logic w_h_short_ar, w_c_short_ar;
    logic w_both_red, w_conflict;
    fault_code_e w_viol_code;

    logic [AW-1:0] ar_q, ar_d;
    logic [FW-1:0] flash_q, flash_d;
    logic          fault_q, fault_d;
    fault_code_e   code_q, code_d;
    logic          lamp_en_q, lamp_en_d;
    logic [1:0]    hwy_lamp_q, hwy_lamp_d;
    logic [1:0]    cntry_lamp_q, cntry_lamp_d;

    traffic_conflict_monitor_aspect_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_hwy (
        .clock        (clock),
        .clear        (clear),
        .aspect       (hwy),
        .step_illegal (w_h_step),
        .short_yellow (w_h_short_y),
        .enter_green  (w_h_enter_g),
        .enc_bad      (w_h_enc)
    );

    traffic_conflict_monitor_aspect_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_cntry (
        .clock        (clock),
        .clear        (clear),
        .aspect       (cntry),
        .step_illegal (w_c_step),
        .short_yellow (w_c_short_y),
        .enter_green  (w_c_enter_g),
        .enc_bad      (w_c_enc)
    );

    // A zero minimum disables the all-red check for that road entirely.
    generate
        if (MIN_ALLRED_H > 0) begin : g_allred_h
            assign w_h_short_ar = w_h_enter_g & (ar_q < AW'(MIN_ALLRED_H));
        end else begin : g_allred_h_off
            assign w_h_short_ar = w_h_enter_g & 1'b0;
        end
        if (MIN_ALLRED_C > 0) begin : g_allred_c
            assign w_c_short_ar = w_c_enter_g & (ar_q < AW'(MIN_ALLRED_C));
        end else begin : g_allred_c_off
            assign w_c_short_ar = w_c_enter_g & 1'b0;
        end
    endgenerate

    assign w_both_red = (hwy == ASP_RED) && (cntry == ASP_RED);
    assign w_conflict = (hwy != ASP_RED) && (cntry != ASP_RED);

    always_comb begin
        w_viol_code = FC_NONE;
        if (w_conflict)                        w_viol_code = FC_CONFLICT;
        else if (w_h_step || w_c_step)         w_viol_code = FC_STEP;
        else if (w_h_short_y || w_c_short_y)   w_viol_code = FC_SHORT_YELLOW;
        else if (w_h_short_ar || w_c_short_ar) w_viol_code = FC_SHORT_ALLRED;
        else if (w_h_enc || w_c_enc)           w_viol_code = FC_ENCODING;
    end

    always_comb begin
        ar_d      = '0;
        if (w_both_red) begin
            ar_d = (ar_q == C_AR_SAT) ? ar_q : ar_q + 1'b1;
        end

        fault_d   = fault_q;
        code_d    = code_q;
        flash_d   = flash_q;
        lamp_en_d = lamp_en_q;
        if (!fault_q) begin
            if (w_viol_code != FC_NONE) begin
                fault_d   = 1'b1;
                code_d    = w_viol_code;
                flash_d   = '0;
                lamp_en_d = 1'b1;
            end
        end else if ((w_viol_code == FC_NONE) && fault_ack && w_both_red) begin
            fault_d   = 1'b0;
            code_d    = FC_NONE;
            flash_d   = '0;
            lamp_en_d = 1'b1;
        end else if (flash_q == C_FLASH_TC) begin
            flash_d   = '0;
            lamp_en_d = ~lamp_en_q;
        end else begin
            flash_d   = flash_q + 1'b1;
        end

        hwy_lamp_d   = fault_d ? ASP_RED : hwy;
        cntry_lamp_d = fault_d ? ASP_RED : cntry;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ar_q         <= C_AR_SAT;
            flash_q      <= '0;
            fault_q      <= 1'b0;
            code_q       <= FC_NONE;
            lamp_en_q    <= 1'b1;
            hwy_lamp_q   <= ASP_RED;
            cntry_lamp_q <= ASP_RED;
        end else begin
            ar_q         <= ar_d;
            flash_q      <= flash_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            lamp_en_q    <= lamp_en_d;
            hwy_lamp_q   <= hwy_lamp_d;
            cntry_lamp_q <= cntry_lamp_d;
        end
    end

    assign hwy_lamp   = hwy_lamp_q;
    assign cntry_lamp = cntry_lamp_q;
    assign lamp_en    = lamp_en_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
// ============================================================================
// Module  : tb_traffic_conflict_monitor
// Brief   : Scoreboard bench with a sequence-level reference model of the monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_traffic_conflict_monitor;

    localparam int MIN_YELLOW   = 3;
    localparam int MIN_ALLRED_C = 2;
    localparam int MIN_ALLRED_H = 0;
    localparam int FLASH_HALF   = 4;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;
    localparam logic [1:0] X = 2'd3;

    typedef struct {
        logic [1:0] hl;
        logic [1:0] cl;
        logic       len;
        logic       flt;
        logic [2:0] code;
    } exp_t;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [1:0] hwy   = 2'd0;
    logic [1:0] cntry = 2'd0;
    logic       fault_ack = 1'b0;
    logic [1:0] hwy_lamp, cntry_lamp;
    logic       lamp_en, fault;
    logic [2:0] fault_code;

    int total = 0;
    int bad   = 0;
    exp_t sb_q[$];
    bit   stim_done = 1'b0;

    traffic_conflict_monitor #(
        .MIN_YELLOW   (MIN_YELLOW),
        .MIN_ALLRED_C (MIN_ALLRED_C),
        .MIN_ALLRED_H (MIN_ALLRED_H),
        .FLASH_HALF   (FLASH_HALF)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .hwy        (hwy),
        .cntry      (cntry),
        .fault_ack  (fault_ack),
        .hwy_lamp   (hwy_lamp),
        .cntry_lamp (cntry_lamp),
        .lamp_en    (lamp_en),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clock = ~clock;

    // Reference model state: run lengths of the aspect history plus fault age.
    logic [1:0] m_ph, m_pc;
    int  m_yel_h, m_yel_c, m_allred;
    bit  m_fault;
    int  m_code;
    int  m_age;

    task automatic cmp(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = R; m_pc = R;
        m_yel_h = 0; m_yel_c = 0;
        m_allred = 1000;
        m_fault = 1'b0; m_code = 0; m_age = 0;
    endtask

    function automatic bit wrong_order(input logic [1:0] p, input logic [1:0] n);
        return (p == G && n == R) || (p == R && n == Y) || (p == Y && n == G);
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.hl = R; e.cl = R; e.len = 1'b1; e.flt = 1'b0; e.code = 3'd0;
        return e;
    endfunction

    task automatic model_step(input logic [1:0] h, input logic [1:0] c, input bit ack,
                              output exp_t e);
        int v;
        v = 0;
        if (h == X || c == X) v = 5;
        if ((m_ph == R && h == G && m_allred < MIN_ALLRED_H) ||
            (m_pc == R && c == G && m_allred < MIN_ALLRED_C)) v = 4;
        if ((m_ph == Y && h == R && m_yel_h < MIN_YELLOW) ||
            (m_pc == Y && c == R && m_yel_c < MIN_YELLOW)) v = 3;
        if (wrong_order(m_ph, h) || wrong_order(m_pc, c)) v = 2;
        if (h != R && c != R) v = 1;

        if (!m_fault) begin
            if (v != 0) begin
                m_fault = 1'b1; m_code = v; m_age = 0;
            end
        end else if (v == 0 && ack && h == R && c == R) begin
            m_fault = 1'b0; m_code = 0;
        end else begin
            m_age++;
        end

        m_yel_h  = (h == Y) ? m_yel_h + 1 : 0;
        m_yel_c  = (c == Y) ? m_yel_c + 1 : 0;
        m_allred = (h == R && c == R) ? m_allred + 1 : 0;
        m_ph = h; m_pc = c;

        e.hl   = m_fault ? R : h;
        e.cl   = m_fault ? R : c;
        e.len  = m_fault ? (((m_age / FLASH_HALF) % 2) == 0) : 1'b1;
        e.flt  = m_fault;
        e.code = 3'(m_code);
    endtask

    task automatic step(input logic [1:0] h, input logic [1:0] c, input bit ack);
        exp_t e;
        @(negedge clock);
        clear = 1'b0; hwy = h; cntry = c; fault_ack = ack;
        model_step(h, c, ack, e);
        sb_q.push_back(e);
    endtask

    task automatic hold(input logic [1:0] h, input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) step(h, c, 1'b0);
    endtask

    // Clear is asynchronous: outputs must be at reset values before any edge.
    task automatic do_clear(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            clear = 1'b1; fault_ack = 1'b0;
            model_reset();
            sb_q.push_back(reset_exp());
            #1;
            cmp("clear_async_hwy_lamp", int'(hwy_lamp), int'(R));
            cmp("clear_async_cntry_lamp", int'(cntry_lamp), int'(R));
            cmp("clear_async_lamp_en", int'(lamp_en), 1);
            cmp("clear_async_fault", int'(fault), 0);
            cmp("clear_async_code", int'(fault_code), 0);
        end
    endtask

    function automatic logic [1:0] pick_aspect();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45) return R;
        if (r < 70) return Y;
        if (r < 95) return G;
        return X;
    endfunction

    // Monitor: one output sample per active edge, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp("hwy_lamp", int'(hwy_lamp), int'(e.hl));
                cmp("cntry_lamp", int'(cntry_lamp), int'(e.cl));
                cmp("lamp_en", int'(lamp_en), int'(e.len));
                cmp("fault", int'(fault), int'(e.flt));
                cmp("fault_code", int'(fault_code), int'(e.code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before stimulus completed");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rh, rc;
        model_reset();
        hwy = G; cntry = R;
        do_clear(5);

        // Legal full cycle
        hold(G, R, 8); hold(Y, R, 3); hold(R, R, 2);
        hold(R, G, 8); hold(R, Y, 3); hold(G, R, 4);

        // Conflict, then flash while faulted, then acknowledge
        step(G, G, 1'b0);
        hold(R, R, 12);
        step(R, R, 1'b1);
        hold(R, R, 2);

        // Short yellow, then short all-red
        hold(G, R, 3); hold(Y, R, 2); step(R, R, 1'b0);
        hold(R, R, 2); step(R, R, 1'b1);
        hold(G, R, 2); hold(Y, R, 3); step(R, R, 1'b0); step(R, G, 1'b0);
        hold(R, R, 3); step(R, R, 1'b1);

        // Encoding, priority of conflict over encoding, direct G->R
        step(X, R, 1'b0); step(R, R, 1'b1);
        step(X, G, 1'b0); step(R, R, 1'b1); step(R, R, 1'b1);
        step(G, R, 1'b0); step(R, R, 1'b0);

        // Ack rejected unless inputs are all-red, then accepted
        step(G, R, 1'b1); step(R, R, 1'b1); step(R, R, 1'b1);
        hold(R, R, 2);
        step(G, G, 1'b0); hold(R, R, 5);
        do_clear(1);
        hold(R, R, 3);

        // Randomized traffic with occasional acks and clears
        rh = R; rc = R;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_clear(1);
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    rh = pick_aspect();
                    rc = pick_aspect();
                end
                step(rh, rc, ($urandom_range(0, 9) < 3));
            end
        end

        repeat (3) @(posedge clock);
        #2;
        cmp("scoreboard_drained", sb_q.size(), 0);
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
